multiplier_arbiter: RTL and testbench

//  Round-robin arbiter that shares one iterative multiplier between N_REQ requesters.
//  - Accepts operand pairs, issues them to the multiplier one at a time, tracks completion.
//  - Returns each product tagged with the requester id.
//  - Sits between client blocks and the multiplier: drives in_a/in_b/in_vld, watches res/res_rdy.

---
 rtl/multiplier_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_multiplier_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_arbiter.sv
// Round-robin arbiter sharing one iterative multiplier between N_REQ requesters.
// Optional abort-on-timeout watchdog enabled by defining MULTIPLIER_ARB_TIMEOUT_EN.
module multiplier_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_vld,
    input  logic [N_REQ*WIDTH-1:0]     req_a,
    input  logic [N_REQ*WIDTH-1:0]     req_b,
    output logic [N_REQ-1:0]           req_rdy,
    output logic                       rsp_vld,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [2*WIDTH-1:0]         rsp_res,
    output logic [WIDTH-1:0]           mul_in_a,
    output logic [WIDTH-1:0]           mul_in_b,
    output logic                       mul_in_vld,
    input  logic [2*WIDTH-1:0]         mul_res,
    input  logic                       mul_res_rdy,
    output logic                       busy,
    output logic                       err,
    output logic [$clog2(N_REQ)-1:0]   err_id
);

    localparam int ID_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 16 || WIDTH < 1 || TIMEOUT < 1) begin : g_param_check
        $error("multiplier_arbiter: parameter out of range");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_BUSY  = 3'd2,
        ST_DONE  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [ID_W-1:0]    ptr_r;
    logic [ID_W-1:0]    id_r;
    logic [ID_W-1:0]    id_inc_s;
    logic [ID_W-1:0]    grant_id_s;
    logic               grant_found_s;
    logic               xfer_s;
    logic               complete_s;
    logic               timeout_hit_s;
    logic [WIDTH-1:0]   op_a_r;
    logic [WIDTH-1:0]   op_b_r;
    logic               mul_in_vld_r;
    logic               rsp_vld_r;
    logic [ID_W-1:0]    rsp_id_r;
    logic [2*WIDTH-1:0] rsp_res_r;
    logic               busy_r;
    logic               err_r;
    logic [ID_W-1:0]    err_id_r;

    // Round-robin search: first active requester at or above ptr, wrapping.
    always_comb begin
        logic [ID_W-1:0] idx_v;
        idx_v         = {ID_W{1'b0}};
        grant_found_s = 1'b0;
        grant_id_s    = {ID_W{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            idx_v = ID_W'((int'(ptr_r) + k) % N_REQ);
            if (!grant_found_s && req_vld[idx_v]) begin
                grant_found_s = 1'b1;
                grant_id_s    = idx_v;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Grant, completion and pointer-advance decodes.
    always_comb begin
        xfer_s     = (state_r == ST_IDLE) && mul_res_rdy && grant_found_s;
        complete_s = (state_r == ST_DONE) && mul_res_rdy;
        req_rdy    = {N_REQ{1'b0}};
        if (xfer_s) begin
            req_rdy[grant_id_s] = 1'b1;
        end else begin
            req_rdy = {N_REQ{1'b0}};
        end
        if (id_r == ID_W'(N_REQ - 1)) begin
            id_inc_s = {ID_W{1'b0}};
        end else begin
            id_inc_s = id_r + ID_W'(1);
        end
    end

`ifdef MULTIPLIER_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_r;

    // Watchdog counter: cleared on issue, counts every cycle spent waiting on the multiplier.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_ISSUE) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_BUSY) || (state_r == ST_DONE)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // A normal completion in the final allowed cycle wins over the abort.
    assign timeout_hit_s = ((state_r == ST_BUSY) || (state_r == ST_DONE)) && !complete_s
                           && (cnt_r == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (xfer_s) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_next_s = ST_BUSY;
            end
            ST_BUSY: begin
                if (timeout_hit_s) begin
                    state_next_s = ST_IDLE;
                end else if (!mul_res_rdy) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (complete_s) begin
                    state_next_s = ST_RESP;
                end else if (timeout_hit_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            ST_RESP: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand/id latches and the rotation pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r  <= {ID_W{1'b0}};
            id_r   <= {ID_W{1'b0}};
            op_a_r <= {WIDTH{1'b0}};
            op_b_r <= {WIDTH{1'b0}};
        end else begin
            if (xfer_s) begin
                id_r   <= grant_id_s;
                op_a_r <= req_a[grant_id_s*WIDTH +: WIDTH];
                op_b_r <= req_b[grant_id_s*WIDTH +: WIDTH];
            end else begin
                id_r   <= id_r;
                op_a_r <= op_a_r;
                op_b_r <= op_b_r;
            end
            if ((state_r == ST_RESP) || timeout_hit_s) begin
                ptr_r <= id_inc_s;
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    // Registered outputs towards the multiplier and the requesters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_in_vld_r <= 1'b0;
            rsp_vld_r    <= 1'b0;
            rsp_id_r     <= {ID_W{1'b0}};
            rsp_res_r    <= {(2*WIDTH){1'b0}};
            busy_r       <= 1'b0;
            err_r        <= 1'b0;
            err_id_r     <= {ID_W{1'b0}};
        end else begin
            mul_in_vld_r <= xfer_s;
            rsp_vld_r    <= complete_s;
            busy_r       <= (state_next_s != ST_IDLE);
            err_r        <= timeout_hit_s;
            if (complete_s) begin
                rsp_id_r  <= id_r;
                rsp_res_r <= mul_res;
            end else begin
                rsp_id_r  <= rsp_id_r;
                rsp_res_r <= rsp_res_r;
            end
            if (timeout_hit_s) begin
                err_id_r <= id_r;
            end else begin
                err_id_r <= err_id_r;
            end
        end
    end

    assign mul_in_a   = op_a_r;
    assign mul_in_b   = op_b_r;
    assign mul_in_vld = mul_in_vld_r;
    assign rsp_vld    = rsp_vld_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_res    = rsp_res_r;
    assign busy       = busy_r;
    assign err        = err_r;
    assign err_id     = err_id_r;

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Randomized self-checking bench for multiplier_arbiter with a transaction-level
// reference model and a behavioural multiplier; timeout checks need MULTIPLIER_ARB_TIMEOUT_EN.
module tb_multiplier_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 64;
    localparam int IW = 2;
`ifdef MULTIPLIER_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam int PH_NONE  = 0;
    localparam int PH_ISSUE = 1;
    localparam int PH_WSTRT = 2;
    localparam int PH_WDONE = 3;
    localparam int PH_RESP  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N-1:0]     req_vld = '0;
    logic [N*W-1:0]   req_a = '0;
    logic [N*W-1:0]   req_b = '0;
    logic [N-1:0]     req_rdy;
    logic             rsp_vld;
    logic [IW-1:0]    rsp_id;
    logic [2*W-1:0]   rsp_res;
    logic [W-1:0]     mul_in_a;
    logic [W-1:0]     mul_in_b;
    logic             mul_in_vld;
    logic [2*W-1:0]   mul_res = '0;
    logic             mul_res_rdy = 1'b1;
    logic             busy;
    logic             err;
    logic [IW-1:0]    err_id;

    multiplier_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_a(req_a), .req_b(req_b), .req_rdy(req_rdy),
        .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_res(rsp_res),
        .mul_in_a(mul_in_a), .mul_in_b(mul_in_b), .mul_in_vld(mul_in_vld),
        .mul_res(mul_res), .mul_res_rdy(mul_res_rdy),
        .busy(busy), .err(err), .err_id(err_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // stimulus
    logic [N-1:0]   stim_vld = '0;
    logic [N*W-1:0] stim_a = '0;
    logic [N*W-1:0] stim_b = '0;
    bit             idle_block_en = 1'b0;

    // behavioural multiplier
    int             mm_left = 0;
    bit             mm_stuck = 1'b0;
    logic [2*W-1:0] mm_prod = '0;

    // reference model of the arbiter
    int             m_phase = PH_NONE;
    int             m_ptr = 0;
    int             m_id = 0;
    int             m_wait = 0;
    logic [2*W-1:0] m_a = '0;
    logic [2*W-1:0] m_b = '0;
    logic [W-1:0]   m_last_a = '0;
    logic [W-1:0]   m_last_b = '0;
    bit             m_err_pend = 1'b0;
    int             m_err_id = 0;

    // observations
    int             rsp_seen = 0;
    int             err_seen = 0;
    int             last_err_cyc = 0;
    logic [IW-1:0]  last_rsp_id = '0;
    logic [2*W-1:0] last_rsp_res = '0;
    logic [IW-1:0]  last_err_id = '0;
    int             dut_glog[$];
    int             grant_cyc[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input int p, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] rand_word();
        int sel;
        sel = $urandom_range(0, 5);
        if (sel == 0) return '0;
        if (sel == 1) return '1;
        return W'($urandom);
    endfunction

    task automatic run_cycle();
        logic [N-1:0]   exp_rdy;
        logic [2*W-1:0] exp_prod;
        int             g;
        bit             done_now;
        @(posedge clk);
        #1;
        cyc++;
        req_vld = stim_vld;
        req_a   = stim_a;
        req_b   = stim_b;
        if (mm_left > 0) begin
            mul_res_rdy = 1'b0;
            mul_res     = (2*W)'($urandom);
        end else begin
            mul_res     = mm_prod;
            mul_res_rdy = !(idle_block_en && m_phase == PH_NONE && $urandom_range(0, 3) == 0);
        end
        @(negedge clk);

        exp_rdy = '0;
        g = -1;
        if (rst && m_phase == PH_NONE && mul_res_rdy && |req_vld) begin
            g = rr_pick(m_ptr, req_vld);
            exp_rdy = N'(1) << g;
        end
        chk("req_rdy", 32'(req_rdy), 32'(exp_rdy));
        chk("mul_in_vld", 32'(mul_in_vld), 32'(m_phase == PH_ISSUE));
        chk("mul_in_a", 32'(mul_in_a), 32'(m_last_a));
        chk("mul_in_b", 32'(mul_in_b), 32'(m_last_b));
        chk("busy", 32'(busy), 32'(m_phase != PH_NONE));
        chk("rsp_vld", 32'(rsp_vld), 32'(m_phase == PH_RESP));
        if (m_phase == PH_RESP) begin
            exp_prod = m_a * m_b;
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
            chk("rsp_res", 32'(rsp_res), 32'(exp_prod));
        end
        chk("err", 32'(err), 32'(m_err_pend));
        if (m_err_pend || !TO_EN) begin
            chk("err_id", 32'(err_id), 32'(m_err_pend ? m_err_id : 0));
        end

        if (rsp_vld) begin
            rsp_seen++;
            last_rsp_id  = rsp_id;
            last_rsp_res = rsp_res;
        end
        if (err) begin
            err_seen++;
            last_err_id  = err_id;
            last_err_cyc = cyc;
        end
        for (int i = 0; i < N; i++) begin
            if (req_rdy[i] && req_vld[i]) begin
                dut_glog.push_back(i);
                grant_cyc.push_back(cyc);
            end
        end

        m_err_pend = 1'b0;
        if (rst) begin
            case (m_phase)
                PH_NONE: begin
                    if (g >= 0) begin
                        m_phase  = PH_ISSUE;
                        m_id     = g;
                        m_last_a = req_a[g*W +: W];
                        m_last_b = req_b[g*W +: W];
                        m_a      = {{W{1'b0}}, m_last_a};
                        m_b      = {{W{1'b0}}, m_last_b};
                    end
                end
                PH_ISSUE: begin
                    m_phase = PH_WSTRT;
                    m_wait  = 0;
                end
                PH_WSTRT, PH_WDONE: begin
                    done_now = (m_phase == PH_WDONE) && mul_res_rdy;
                    m_wait++;
                    if (done_now) begin
                        m_phase = PH_RESP;
                    end else if (TO_EN && m_wait == TO) begin
                        m_err_pend = 1'b1;
                        m_err_id   = m_id;
                        m_phase    = PH_NONE;
                        m_ptr      = (m_id + 1) % N;
                    end else if (m_phase == PH_WSTRT && !mul_res_rdy) begin
                        m_phase = PH_WDONE;
                    end
                end
                PH_RESP: begin
                    m_phase = PH_NONE;
                    m_ptr   = (m_id + 1) % N;
                end
                default: m_phase = PH_NONE;
            endcase
        end

        if (mul_in_vld) begin
            mm_left = $urandom_range(1, 6);
            mm_prod = mul_in_a * mul_in_b;
        end else if (mm_left > 0 && !mm_stuck) begin
            mm_left--;
        end
    endtask

    task automatic wait_rsp(input int n, input int budget);
        int start;
        start = rsp_seen;
        for (int i = 0; i < budget && rsp_seen < start + n; i++) run_cycle();
        chk("wait_rsp", 32'(rsp_seen - start >= n), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && m_phase != PH_NONE; i++) run_cycle();
        run_cycle();
    endtask

    initial begin
        int g0;
        int e0;
        int r0;
        int gc;
        int exp_seq[5];

        // reset state
        for (int i = 0; i < 3; i++) run_cycle();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rsp_res", 32'(rsp_res), 32'd0);
        rst = 1'b1;
        run_cycle();

        // fairness: all requesters held active
        for (int i = 0; i < N; i++) begin
            stim_a[i*W +: W] = rand_word();
            stim_b[i*W +: W] = rand_word();
        end
        stim_vld = 4'b1111;
        g0 = dut_glog.size();
        wait_rsp(5, 200);
        stim_vld = 4'b0000;
        exp_seq = '{0, 1, 2, 3, 0};
        if (dut_glog.size() >= g0 + 5) begin
            for (int k = 0; k < 5; k++) chk("fair_grant", 32'(dut_glog[g0 + k]), 32'(exp_seq[k]));
        end
        drain();

        // single op, requester 2: 12*13
        stim_a[2*W +: W] = 8'd12;
        stim_b[2*W +: W] = 8'd13;
        stim_vld = 4'b0100;
        wait_rsp(1, 100);
        stim_vld = 4'b0000;
        chk("single_id", 32'(last_rsp_id), 32'd2);
        chk("single_res", 32'(last_rsp_res), 32'd156);
        drain();

        // wrap/skip from ptr 3 with requesters 0 and 2
        g0 = dut_glog.size();
        stim_vld = 4'b0101;
        wait_rsp(2, 100);
        stim_vld = 4'b0000;
        if (dut_glog.size() >= g0 + 2) begin
            chk("wrap_first", 32'(dut_glog[g0]), 32'd0);
            chk("wrap_second", 32'(dut_glog[g0 + 1]), 32'd2);
        end
        drain();

        // max operands
        stim_a[1*W +: W] = 8'hFF;
        stim_b[1*W +: W] = 8'hFF;
        stim_vld = 4'b0010;
        wait_rsp(1, 100);
        stim_vld = 4'b0000;
        chk("max_id", 32'(last_rsp_id), 32'd1);
        chk("max_res", 32'(last_rsp_res), 32'hFE01);
        drain();

        // randomized traffic with idle stalls from the multiplier
        idle_block_en = 1'b1;
        r0 = rsp_seen;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) stim_vld = N'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                for (int j = 0; j < N; j++) begin
                    stim_a[j*W +: W] = rand_word();
                    stim_b[j*W +: W] = rand_word();
                end
            end
            run_cycle();
        end
        idle_block_en = 1'b0;
        stim_vld = 4'b0000;
        drain();
        chk("random_progress", 32'(rsp_seen - r0 > 20), 32'd1);

        // reset in the middle of an operation
        stim_vld = 4'b0010;
        for (int i = 0; i < 20 && m_phase != PH_WDONE; i++) run_cycle();
        stim_vld = 4'b0000;
        rst = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_req_rdy", 32'(req_rdy), 32'd0);
        chk("midrst_mul_in_vld", 32'(mul_in_vld), 32'd0);
        chk("midrst_mul_in_a", 32'(mul_in_a), 32'd0);
        chk("midrst_mul_in_b", 32'(mul_in_b), 32'd0);
        chk("midrst_rsp_vld", 32'(rsp_vld), 32'd0);
        chk("midrst_rsp_id", 32'(rsp_id), 32'd0);
        chk("midrst_rsp_res", 32'(rsp_res), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_err_id", 32'(err_id), 32'd0);
        m_phase = PH_NONE; m_ptr = 0; m_last_a = '0; m_last_b = '0; m_err_pend = 1'b0;
        mm_left = 0;
        run_cycle();
        run_cycle();
        rst = 1'b1;
        g0 = dut_glog.size();
        stim_vld = 4'b1111;
        run_cycle();
        stim_vld = 4'b0000;
        chk("post_rst_granted", 32'(dut_glog.size() > g0), 32'd1);
        if (dut_glog.size() > g0) chk("post_rst_grant", 32'(dut_glog[g0]), 32'd0);
        drain();

`ifdef MULTIPLIER_ARB_TIMEOUT_EN
        // multiplier hangs: abort after TIMEOUT cycles, then service resumes
        mm_stuck = 1'b1;
        e0 = err_seen;
        r0 = rsp_seen;
        g0 = dut_glog.size();
        stim_vld = 4'b0010;
        for (int i = 0; i < 10 && dut_glog.size() == g0; i++) run_cycle();
        stim_vld = 4'b0000;
        gc = (grant_cyc.size() > 0) ? grant_cyc[$] : 0;
        for (int i = 0; i < 150 && err_seen == e0; i++) run_cycle();
        chk("to_err_seen", 32'(err_seen - e0), 32'd1);
        chk("to_err_id", 32'(last_err_id), 32'd1);
        chk("to_latency", 32'(last_err_cyc - gc), 32'd66);
        chk("to_no_rsp", 32'(rsp_seen - r0), 32'd0);
        mm_stuck = 1'b0;
        mm_left  = 0;
        stim_a[3*W +: W] = 8'd7;
        stim_b[3*W +: W] = 8'd9;
        stim_vld = 4'b1000;
        wait_rsp(1, 100);
        stim_vld = 4'b0000;
        chk("to_next_id", 32'(last_rsp_id), 32'd3);
        chk("to_next_res", 32'(last_rsp_res), 32'd63);
        drain();
`else
        e0 = 0; r0 = 0; gc = 0;
        chk("no_err_seen", 32'(err_seen), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
